pri_encoder_pipe: RTL and testbench

//  Pipelined, parametrised priority encoder with a valid/ready stream on each side.

---
 rtl/pri_encoder_pipe_if.sv | 30 +++
 rtl/pri_encoder_pipe.sv | 177 +++++++++++++++++
 tb/tb_pri_encoder_pipe.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pri_encoder_pipe_if.sv
// Stream bundle for the pipelined priority encoder: producer side (in_*) and consumer side (out_*).
interface pri_encoder_pipe_if #(
  parameter int unsigned WIDTH     = 56,
  parameter int unsigned WIDTH_LOG = 6,
  parameter int unsigned TAG_W     = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 in_lsb;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH_LOG-1:0] out_idx;
  logic                 out_found;
  logic [TAG_W-1:0]     out_tag;
  logic [15:0]          zero_cnt;

  // Environment side: supplies words and consumes results.
  modport master (
    output in_valid, in_data, in_lsb, in_tag, out_ready,
    input  in_ready, out_valid, out_idx, out_found, out_tag, zero_cnt
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_data, in_lsb, in_tag, out_ready,
    output in_ready, out_valid, out_idx, out_found, out_tag, zero_cnt
  );
endinterface

// File: rtl/pri_encoder_pipe.sv
// Pipelined priority encoder: binary-search tree, one register rank per level, MSB/LSB mode per word.
// Rank 0 holds the padded (optionally reversed) word; rank WIDTH_LOG is the registered output.
module pri_encoder_pipe #(
  parameter int unsigned WIDTH     = 56,
  parameter int unsigned WIDTH_LOG = 6,
  parameter int unsigned TAG_W     = 4
) (
  input logic               clk,
  input logic               rst,
  pri_encoder_pipe_if.slave pipe_io
);
  localparam int unsigned L  = WIDTH_LOG;
  localparam int unsigned P  = 1 << WIDTH_LOG;
  // Windows of ranks 1..L-1 packed back to back: widths P/2, P/4, ..., 2.
  localparam int unsigned RW = (P > 2) ? P - 2 : 1;

  if (WIDTH < 2) begin : g_chk_width
    $error("pri_encoder_pipe: WIDTH must be >= 2");
  end
  if ((1 << WIDTH_LOG) < WIDTH) begin : g_chk_log
    $error("pri_encoder_pipe: 2**WIDTH_LOG must be >= WIDTH");
  end
  if (TAG_W < 1) begin : g_chk_tag
    $error("pri_encoder_pipe: TAG_W must be >= 1");
  end

  // Bit offset of rank k's window inside the packed rank 1..L-1 storage.
  function automatic int unsigned roff(input int unsigned k);
    return P - 2 * (P >> k);
  endfunction

  logic                 adv_c;
  logic                 acc_c;
  logic [P-1:0]         pad_c;
  logic [P-1:0]         rev_c;

  logic [P-1:0]         win0_q, win0_d;
  logic [RW-1:0]        winr_q;
  logic [RW-1:0]        winr_d;
  logic [L-1:0]         vld_q, vld_d;
  logic [L-1:0]         lsb_q, lsb_d;
  logic [TAG_W-1:0]     tag_q [L];
  logic [TAG_W-1:0]     tag_d [L];
  logic [L-1:0]         idx_q [L];
  logic [L-1:0]         idx_d [L];

  logic [L-1:0]         idx_nx [L];
  logic                 last_bit_c;

  logic                 out_valid_q, out_valid_d;
  logic [L-1:0]         out_idx_q, out_idx_d;
  logic                 out_found_q, out_found_d;
  logic [TAG_W-1:0]     out_tag_q, out_tag_d;
  logic [15:0]          zero_cnt_q, zero_cnt_d;

  // Global stall: every rank advances only when the output slot is free or being taken.
  assign adv_c = !out_valid_q | pipe_io.out_ready;
  assign acc_c = pipe_io.in_valid & adv_c;

  always_comb begin
    pad_c = P'(pipe_io.in_data);
    rev_c = '0;
    for (int unsigned b = 0; b < P; b++) begin
      rev_c[b] = pad_c[P-1-b];
    end
  end

  // One tree level per rank: keep the upper half if it has any set bit, else the lower half.
  for (genvar i = 0; i < L; i++) begin : g_lvl
    localparam int unsigned WI = P >> i;
    localparam int unsigned HI = WI / 2;
    logic [WI-1:0] w;
    logic          b;

    if (i == 0) begin : g_src0
      assign w = win0_q;
    end else begin : g_srcr
      assign w = winr_q[roff(i) +: WI];
    end

    assign b         = |w[WI-1:HI];
    assign idx_nx[i] = idx_q[i] | (L'(b) << (L - 1 - i));

    if (i + 1 < L) begin : g_mid
      assign winr_d[roff(i+1) +: HI] = b ? w[WI-1:HI] : w[HI-1:0];
    end else begin : g_last
      // Final one-bit window is set exactly when the original word was non-zero.
      assign last_bit_c = b ? w[WI-1] : w[0];
    end
  end

  if (P <= 2) begin : g_no_mid
    assign winr_d = '0;
  end

  always_comb begin
    win0_d   = '0;
    vld_d    = '0;
    lsb_d    = '0;
    for (int unsigned k = 0; k < L; k++) begin
      tag_d[k] = '0;
      idx_d[k] = '0;
    end

    // Rank 0 capture; idle cycles load a clean bubble so X data never enters the tree.
    vld_d[0] = acc_c;
    if (acc_c) begin
      win0_d   = pipe_io.in_lsb ? rev_c : pad_c;
      lsb_d[0] = pipe_io.in_lsb;
      tag_d[0] = pipe_io.in_tag;
    end

    for (int unsigned k = 1; k < L; k++) begin
      vld_d[k] = vld_q[k-1];
      lsb_d[k] = lsb_q[k-1];
      tag_d[k] = tag_q[k-1];
      idx_d[k] = idx_nx[k-1];
    end

    out_valid_d = vld_q[L-1];
    out_found_d = last_bit_c;
    out_tag_d   = tag_q[L-1];
    if (!last_bit_c) begin
      out_idx_d = '0;
    end else if (lsb_q[L-1]) begin
      out_idx_d = L'(P - 1) - idx_nx[L-1];
    end else begin
      out_idx_d = idx_nx[L-1];
    end

    zero_cnt_d = zero_cnt_q;
    if (out_valid_q && pipe_io.out_ready && !out_found_q && (zero_cnt_q != 16'hFFFF)) begin
      zero_cnt_d = zero_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win0_q      <= '0;
      winr_q      <= '0;
      vld_q       <= '0;
      lsb_q       <= '0;
      for (int unsigned k = 0; k < L; k++) begin
        tag_q[k] <= '0;
        idx_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_found_q <= 1'b0;
      out_tag_q   <= '0;
      zero_cnt_q  <= '0;
    end else begin
      if (adv_c) begin
        win0_q      <= win0_d;
        winr_q      <= winr_d;
        vld_q       <= vld_d;
        lsb_q       <= lsb_d;
        for (int unsigned k = 0; k < L; k++) begin
          tag_q[k] <= tag_d[k];
          idx_q[k] <= idx_d[k];
        end
        out_valid_q <= out_valid_d;
        out_idx_q   <= out_idx_d;
        out_found_q <= out_found_d;
        out_tag_q   <= out_tag_d;
      end
      zero_cnt_q <= zero_cnt_d;
    end
  end

  assign pipe_io.in_ready  = adv_c;
  assign pipe_io.out_valid = out_valid_q;
  assign pipe_io.out_idx   = out_idx_q;
  assign pipe_io.out_found = out_found_q;
  assign pipe_io.out_tag   = out_tag_q;
  assign pipe_io.zero_cnt  = zero_cnt_q;
endmodule

// File: tb/tb_pri_encoder_pipe.sv
// Directed bench for pri_encoder_pipe: hand-computed expectations queued per accepted word.
`timescale 1ns/1ps
module tb_pri_encoder_pipe;
  logic clk;
  logic rst;

  pri_encoder_pipe_if #(.WIDTH(56), .WIDTH_LOG(6), .TAG_W(4)) vif ();

  pri_encoder_pipe #(.WIDTH(56), .WIDTH_LOG(6), .TAG_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .pipe_io (vif)
  );

  typedef struct packed {
    logic [5:0] idx;
    logic       found;
    logic [3:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk   = 0;
  int   n_pass  = 0;
  int   n_deliv = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vif.in_valid = 1'b0;
    vif.in_data  = 'x;
    vif.in_lsb   = 1'b0;
    vif.in_tag   = '0;
  endtask

  // Present a word and hold it until accepted; queue its expected result.
  task automatic send(input logic [55:0] d, input logic lsb, input logic [3:0] tag,
                      input logic [5:0] eidx, input logic efound);
    exp_t e;
    bit   done;
    done         = 1'b0;
    vif.in_valid = 1'b1;
    vif.in_data  = d;
    vif.in_lsb   = lsb;
    vif.in_tag   = tag;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (vif.in_ready) begin
        e.idx   = eidx;
        e.found = efound;
        e.tag   = tag;
        exp_q.push_back(e);
        done    = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) step();
    step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Consumer-side scoreboard: every delivered result must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && vif.out_valid && vif.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_idx", 64'(vif.out_idx), 64'(e.idx));
        chk("out_found", 64'(vif.out_found), 64'(e.found));
        chk("out_tag", 64'(vif.out_tag), 64'(e.tag));
        n_deliv++;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          deliv0;
    logic [55:0] w;
    rst           = 1'b1;
    vif.out_ready = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(vif.out_valid), 64'd0);
    chk("rst_zero_cnt", 64'(vif.zero_cnt), 64'd0);
    chk("rst_out_idx", 64'(vif.out_idx), 64'd0);
    rst = 1'b0;
    step();
    chk("idle_in_ready", 64'(vif.in_ready), 64'd1);

    // MSB mode, back-to-back; first result 6 edges after the first accept edge.
    send(56'h1,                 1'b0, 4'd0, 6'd0,  1'b1);
    send(56'h2,                 1'b0, 4'd1, 6'd1,  1'b1);
    send(56'h20,                1'b0, 4'd2, 6'd5,  1'b1);
    send(56'h7_FFFF_FFFF_FFFF,  1'b0, 4'd3, 6'd50, 1'b1);
    send(56'h0,                 1'b0, 4'd4, 6'd0,  1'b0);
    idle();
    chk("lat_edge4", 64'(vif.out_valid), 64'd0);
    step();
    chk("lat_edge5", 64'(vif.out_valid), 64'd0);
    step();
    chk("lat_edge6", 64'(vif.out_valid), 64'd1);
    drain();
    chk("zero_cnt_1", 64'(vif.zero_cnt), 64'd1);

    // LSB mode, then one MSB word at the top bit.
    send(56'h7_FFFF_FFFF_FFFF,  1'b1, 4'd5, 6'd0,  1'b1);
    send(56'h20,                1'b1, 4'd6, 6'd5,  1'b1);
    send(56'h80_0000_0000_0000, 1'b1, 4'd7, 6'd55, 1'b1);
    send(56'h1,                 1'b1, 4'd8, 6'd0,  1'b1);
    send(56'h80_0000_0000_0000, 1'b0, 4'd9, 6'd55, 1'b1);
    idle();
    drain();

    // Mode alternating per word on 0x0F0: MSB -> 7, LSB -> 4.
    for (int t = 0; t < 8; t++) begin
      send(56'h0F0, t[0], 4'(t), t[0] ? 6'd4 : 6'd7, 1'b1);
    end
    idle();
    drain();

    // Fill all seven ranks with the consumer stalled, then hold for 10 cycles.
    deliv0        = n_deliv;
    vif.out_ready = 1'b0;
    for (int t = 0; t < 7; t++) begin
      w = 56'(1) << (3 + t);
      send(w, 1'b0, 4'(t), 6'(3 + t), 1'b1);
    end
    vif.in_valid = 1'b1;
    vif.in_data  = 56'(1) << 10;
    vif.in_lsb   = 1'b0;
    vif.in_tag   = 4'd7;
    for (int c = 0; c < 10; c++) begin
      chk("stall_in_ready", 64'(vif.in_ready), 64'd0);
      chk("stall_valid", 64'(vif.out_valid), 64'd1);
      chk("stall_tag", 64'(vif.out_tag), 64'd0);
      chk("stall_idx", 64'(vif.out_idx), 64'd3);
      step();
    end
    vif.out_ready = 1'b1;
    for (int t = 7; t < 10; t++) begin
      w = 56'(1) << (3 + t);
      send(w, 1'b0, 4'(t), 6'(3 + t), 1'b1);
    end
    idle();
    drain();
    chk("stall_count", 64'(n_deliv - deliv0), 64'd10);

    // Mid-cycle reset with four words in the pipe, head word waiting at the output.
    vif.out_ready = 1'b0;
    send(56'h4,    1'b0, 4'd0, 6'd2,  1'b1);
    send(56'h0,    1'b0, 4'd1, 6'd0,  1'b0);
    send(56'h100,  1'b1, 4'd2, 6'd8,  1'b1);
    send(56'h3000, 1'b0, 4'd3, 6'd13, 1'b1);
    idle();
    repeat (3) step();
    chk("pre_rst_valid", 64'(vif.out_valid), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(vif.out_valid), 64'd0);
    chk("async_rst_zero_cnt", 64'(vif.zero_cnt), 64'd0);
    chk("async_rst_tag", 64'(vif.out_tag), 64'd0);
    exp_q.delete();
    deliv0        = n_deliv;
    vif.out_ready = 1'b1;
    #8 rst = 1'b0;
    repeat (12) step();
    chk("no_stale_count", 64'(n_deliv - deliv0), 64'd0);
    chk("no_stale_valid", 64'(vif.out_valid), 64'd0);

    // Saturation of the zero-result counter.
    for (int i = 0; i < 70000; i++) begin
      send(56'h0, 1'b0, 4'(i), 6'd0, 1'b0);
    end
    idle();
    drain();
    chk("zero_cnt_sat", 64'(vif.zero_cnt), 64'hFFFF);
    chk("zero_run_count", 64'(n_deliv - deliv0), 64'd70000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
